// File: rtl/pipelined_csel_adder_if.sv
// Operand/result handshake bundle for pipelined_csel_adder.
// The master drives operands and out_ready. The slave (the adder) returns
// in_ready and the result.
interface pipelined_csel_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/pipelined_csel_adder.sv
// Pipelined WIDTH-bit adder/subtractor. Each stage resolves one BLK-bit slice.
// Stage k holds:
//   - sum slices 0..k, already resolved;
//   - the registered carry out of slice k;
//   - the operand slices still pending, shifted down so that the next slice
//     to resolve always sits in bits [BLK-1:0].
// Stalls are handled by a per-stage enable that lets bubbles collapse.
// The enable is combinational from out_ready back to in_ready.
module pipelined_csel_adder #(
  parameter int WIDTH = 64,
  parameter int BLK   = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_csel_adder_if.slave bus
);

  localparam int NBLK = WIDTH / BLK;

  if (WIDTH % BLK != 0) begin : g_bad_width
    $error("pipelined_csel_adder: WIDTH must be a multiple of BLK");
  end

  logic             v      [NBLK];
  logic             st_c   [NBLK];
  logic [WIDTH-1:0] st_sum [NBLK];
  logic [WIDTH-1:0] st_pa  [NBLK];
  logic [WIDTH-1:0] st_pb  [NBLK];
  logic [NBLK-1:0]  en;
  logic             full_acc;
  logic             c_msb;
  logic             in_ready_i;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.cin ^ bus.sub;

  // A stage may load unless it and every stage downstream of it are full
  // while the consumer is stalling.
  always_comb begin
    full_acc = 1'b1;
    en       = '0;
    for (int k = NBLK - 1; k >= 0; k--) begin
      full_acc = full_acc & v[k];
      en[k]    = bus.out_ready | ~full_acc;
    end
  end

  assign in_ready_i = en[0] & ~rst;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    logic             src_v;
    logic             src_c;
    logic [WIDTH-1:0] src_sum;
    logic [WIDTH-1:0] src_pa;
    logic [WIDTH-1:0] src_pb;
    logic [WIDTH-1:0] nxt_sum;
    logic [BLK:0]     slice;

    if (k == 0) begin : g_head
      assign src_v   = bus.in_valid & in_ready_i;
      assign src_c   = cin_eff;
      assign src_sum = '0;
      assign src_pa  = bus.a;
      assign src_pb  = b_eff;
    end else begin : g_tail
      assign src_v   = v[k-1];
      assign src_c   = st_c[k-1];
      assign src_sum = st_sum[k-1];
      assign src_pa  = st_pa[k-1];
      assign src_pb  = st_pb[k-1];
    end

    assign slice = {1'b0, src_pa[BLK-1:0]} + {1'b0, src_pb[BLK-1:0]}
                 + {{BLK{1'b0}}, src_c};

    // Merge the freshly resolved slice into the partial sum from upstream.
    always_comb begin
      nxt_sum = src_sum;
      nxt_sum[k*BLK +: BLK] = slice[BLK-1:0];
    end

    // Stage register: load upstream contents whenever this stage is enabled.
    always_ff @(posedge clk) begin
      if (rst) begin
        v[k]      <= 1'b0;
        st_c[k]   <= 1'b0;
        st_sum[k] <= '0;
        st_pa[k]  <= '0;
        st_pb[k]  <= '0;
      end else if (en[k]) begin
        v[k]      <= src_v;
        st_c[k]   <= slice[BLK];
        st_sum[k] <= nxt_sum;
        st_pa[k]  <= src_pa >> BLK;
        st_pb[k]  <= src_pb >> BLK;
      end
    end

    if (k == NBLK - 1) begin : g_last
      // Carry into the MSB, recovered from the MSB sum bit, feeds overflow.
      always_ff @(posedge clk) begin
        if (rst) begin
          c_msb <= 1'b0;
        end else if (en[k]) begin
          c_msb <= src_pa[BLK-1] ^ src_pb[BLK-1] ^ slice[BLK-1];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = v[NBLK-1];
  assign bus.sum       = st_sum[NBLK-1];
  assign bus.c_out     = st_c[NBLK-1];
  assign bus.ovf       = c_msb ^ st_c[NBLK-1];

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboard bench for pipelined_csel_adder.
// The main DUT uses 64/16 (4 stages). A second instance uses 64/64 and
// exercises the single-stage case.
module tb_pipelined_csel_adder;

  localparam int NBLK = 4;

  typedef struct {
    logic [63:0] sum;
    logic        c;
    logic        ovf;
    int          edge_acc;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;
  bit   lat_chk  = 0;
  exp_t sb[$];

  pipelined_csel_adder_if #(.WIDTH(64)) bus ();
  pipelined_csel_adder_if #(.WIDTH(64)) bus1 ();

  pipelined_csel_adder #(.WIDTH(64), .BLK(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipelined_csel_adder #(.WIDTH(64), .BLK(64)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  // Reference: plain wide arithmetic. Overflow is computed from the sign rule.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [63:0] bb;
    logic [64:0] full;
    bb       = sub ? ~b : b;
    full     = {1'b0, a} + {1'b0, bb} + 65'(cin ^ sub);
    e.sum    = full[63:0];
    e.c      = full[64];
    e.ovf    = (a[63] == bb[63]) && (e.sum[63] != a[63]);
    e.edge_acc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic cin, input logic sub);
    exp_t e;
    int   guard;
    e = model(a, b, cin, sub);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    guard        = 0;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.edge_acc = edge_n + 1;
        sb.push_back(e);
        break;
      end
      guard++;
      if (guard > 100) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    #1;
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks that
  // data holds steady across stall cycles.
  initial begin
    exp_t        e;
    bit          stall_prev;
    logic [63:0] st_sum;
    logic [1:0]  st_flags;
    stall_prev = 0;
    st_sum     = '0;
    st_flags   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 0;
      end else begin
        if (stall_prev && bus.out_valid) begin
          chk("stall_sum", bus.sum, st_sum);
          chk("stall_flags", {62'd0, bus.c_out, bus.ovf}, {62'd0, st_flags});
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got sum %h, expected no result", bus.sum);
          end else begin
            e = sb.pop_front();
            chk("sum", bus.sum, e.sum);
            chk("c_out", {63'd0, bus.c_out}, {63'd0, e.c});
            chk("ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
            if (lat_chk) chk("latency", 64'(edge_n - e.edge_acc), 64'(NBLK - 1));
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        st_sum     = bus.sum;
        st_flags   = {bus.c_out, bus.ovf};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 64'h1234;
    bus.b         = 64'h5678;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0;
    bus1.a        = '0;
    bus1.b        = '0;
    bus1.cin      = 1'b0;
    bus1.sub      = 1'b0;
    bus1.out_ready = 1'b1;

    // Reset, with in_valid held high
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready2", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid2", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_sum", bus.sum, 64'd0);
    chk("rst_c_out", {63'd0, bus.c_out}, 64'd0);
    chk("rst_ovf", {63'd0, bus.ovf}, 64'd0);
    chk("rst_s1_out_valid", {63'd0, bus1.out_valid}, 64'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // Full carry ripple, then subtract and overflow
    lat_chk = 1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    drain("drain_ripple");
    send(64'd5, 64'd7, 1'b0, 1'b1);
    drain("drain_sub");
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    drain("drain_ovf");

    // 16 back-to-back random vectors
    t0 = edge_n;
    for (int i = 0; i < 16; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    chk("stream_accept_cycles", 64'(edge_n - t0), 64'd16);
    drain("drain_stream");

    // Backpressure: out_ready low for 6 cycles while streaming
    lat_chk = 0;
    fork
      begin
        for (int i = 0; i < 12; i++)
          send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("full_held", 64'(sb.size()), 64'd4);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset with 3 transactions in flight
    lat_chk = 1;
    for (int i = 0; i < 3; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    send(64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    drain("drain_after_midrst");

    // Single-stage instance: one-cycle latency
    bus1.a        = 64'hFFFF_FFFF_FFFF_FFFF;
    bus1.b        = 64'd0;
    bus1.cin      = 1'b1;
    bus1.sub      = 1'b0;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    chk("s1_in_ready", {63'd0, bus1.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    chk("s1_out_valid", {63'd0, bus1.out_valid}, 64'd1);
    chk("s1_sum", bus1.sum, 64'd0);
    chk("s1_c_out", {63'd0, bus1.c_out}, 64'd1);
    chk("s1_ovf", {63'd0, bus1.ovf}, 64'd0);
    @(posedge clk);
    #1;
    bus1.a        = 64'h8000_0000_0000_0000;
    bus1.b        = 64'd1;
    bus1.cin      = 1'b0;
    bus1.sub      = 1'b1;
    bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    chk("s1_sub_sum", bus1.sum, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("s1_sub_c_out", {63'd0, bus1.c_out}, 64'd1);
    chk("s1_sub_ovf", {63'd0, bus1.ovf}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("s1_drained", {63'd0, bus1.out_valid}, 64'd0);

    repeat (4) @(posedge clk);
    #1;
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
